// File: rtl/elevator_scan_ctrl_if.sv
// Call inputs and status outputs of the SCAN elevator controller.
// The board/bench side uses master; the controller uses slave.
interface elevator_scan_ctrl_if #(
    parameter int NUM_FLOORS = 10,
    parameter int FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] call_req;
    logic                  estop;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  moving_up;
    logic                  moving_down;
    logic                  door_open;
    logic                  idle;
    logic [NUM_FLOORS-1:0] pending;

    modport master (
        output call_req, estop,
        input  current_floor, moving_up, moving_down, door_open, idle, pending
    );

    modport slave (
        input  call_req, estop,
        output current_floor, moving_up, moving_down, door_open, idle, pending
    );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latched per-floor calls, timed travel and
// door dwell, emergency-stop freeze.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS   = 10,
    parameter int FLOOR_W      = 4,
    parameter int TRAVEL_TICKS = 10000000,
    parameter int DOOR_TICKS   = 20000000
) (
    input  logic                clk,
    input  logic                rst_n,
    elevator_scan_ctrl_if.slave bus
);
    localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TIMER_W-1:0]    TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0]    DOOR_LAST   = TIMER_W'(DOOR_TICKS - 1);
    localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                r_state, w_state_nxt, w_go_state;
    logic [FLOOR_W-1:0]    r_floor, w_floor_nxt, w_eval_floor;
    logic                  r_dir_up, w_dir_up_nxt, w_go_dir_up;
    logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
    logic [NUM_FLOORS-1:0] w_cur_hot, w_eval_hot, w_below_mask;
    logic                  w_travel_done, w_door_done, w_call_here, w_decide;
    logic                  w_hit, w_above, w_below;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_dir_up  <= 1'b1;
            r_timer   <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_travel_done = (r_timer == TRAVEL_LAST);
        w_door_done   = (r_timer == DOOR_LAST);
        w_cur_hot     = ONE << r_floor;
        w_call_here   = (r_state == DOOR_OPEN) && (|(bus.call_req & w_cur_hot));

        // A decision point evaluates the floor the car will be at after this edge.
        w_eval_floor = r_floor;
        w_decide     = 1'b0;
        case (r_state)
            IDLE:      w_decide = 1'b1;
            MOVE_UP: begin
                w_decide = w_travel_done;
                if (w_travel_done) w_eval_floor = r_floor + FLOOR_W'(1);
            end
            MOVE_DOWN: begin
                w_decide = w_travel_done;
                if (w_travel_done) w_eval_floor = r_floor - FLOOR_W'(1);
            end
            DOOR_OPEN: w_decide = w_door_done && !w_call_here;
            default:   w_decide = 1'b0;
        endcase

        w_eval_hot   = ONE << w_eval_floor;
        w_below_mask = w_eval_hot - ONE;
        w_hit        = |(r_pending & w_eval_hot);
        w_below      = |(r_pending & w_below_mask);
        w_above      = |(r_pending & ~(w_below_mask | w_eval_hot));

        // dir_up always matches the current travel direction, so one rule
        // covers idle start, arrival (continue/reverse) and door departure.
        w_go_state  = IDLE;
        w_go_dir_up = r_dir_up;
        if (w_hit) begin
            w_go_state = DOOR_OPEN;
        end else if (w_above && (r_dir_up || !w_below)) begin
            w_go_state  = MOVE_UP;
            w_go_dir_up = 1'b1;
        end else if (w_below) begin
            w_go_state  = MOVE_DOWN;
            w_go_dir_up = 1'b0;
        end

        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_up_nxt = r_dir_up;
        w_timer_nxt  = r_timer;
        if (!bus.estop) begin
            w_timer_nxt = w_call_here ? '0 : r_timer + TIMER_W'(1);
            if (w_decide) begin
                w_state_nxt  = w_go_state;
                w_floor_nxt  = w_eval_floor;
                w_dir_up_nxt = w_go_dir_up;
                w_timer_nxt  = '0;
            end
        end

        w_pending_nxt = r_pending | (bus.call_req & ((r_state == DOOR_OPEN) ? ~w_cur_hot : '1));
        if (w_state_nxt == DOOR_OPEN && r_state != DOOR_OPEN)
            w_pending_nxt = w_pending_nxt & ~w_eval_hot;
    end

    always_comb begin
        bus.idle        = 1'b0;
        bus.moving_up   = 1'b0;
        bus.moving_down = 1'b0;
        bus.door_open   = 1'b0;
        case (r_state)
            IDLE:      bus.idle        = 1'b1;
            MOVE_UP:   bus.moving_up   = 1'b1;
            MOVE_DOWN: bus.moving_down = 1'b1;
            DOOR_OPEN: bus.door_open   = 1'b1;
            default:   bus.idle        = 1'b0;
        endcase
    end

    assign bus.current_floor = r_floor;
    assign bus.pending       = r_pending;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: countdown-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed timing.
module tb_elevator_scan_ctrl;
    localparam int NF = 10;
    localparam int FW = 4;
    localparam int TT = 4;
    localparam int DT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    elevator_scan_ctrl_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus_if ();

    elevator_scan_ctrl #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
    mode_t          m_mode  = M_IDLE;
    int             m_floor = 0;
    bit             m_dir   = 1'b1;
    int             m_left  = 0;
    logic [NF-1:0]  m_pend  = '0;

    function automatic bit ahead(input logic [NF-1:0] p, input int f, input bit up);
        for (int i = 0; i < NF; i++)
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [NF-1:0] c, input logic e);
        mode_t         nm;
        int            nf;
        bit            nd;
        bit            leg;
        bit            up;
        logic [NF-1:0] np;
        nm  = m_mode;
        nf  = m_floor;
        nd  = m_dir;
        leg = 1'b0;
        np  = m_pend | c;
        if (m_mode == M_DOOR) np[m_floor] = m_pend[m_floor];
        if (!e) begin
            case (m_mode)
                M_IDLE: begin
                    if (m_pend[m_floor]) nm = M_DOOR;
                    else if (ahead(m_pend, m_floor, 1'b1) && (m_dir || !ahead(m_pend, m_floor, 1'b0))) begin
                        nm = M_UP; nd = 1'b1;
                    end else if (ahead(m_pend, m_floor, 1'b0)) begin
                        nm = M_DOWN; nd = 1'b0;
                    end
                end
                M_UP, M_DOWN: begin
                    if (m_left == 1) begin
                        up  = (m_mode == M_UP);
                        nf  = up ? m_floor + 1 : m_floor - 1;
                        leg = 1'b1;
                        if (m_pend[nf]) nm = M_DOOR;
                        else if (ahead(m_pend, nf, up)) nm = m_mode;
                        else if (ahead(m_pend, nf, !up)) begin
                            nm = up ? M_DOWN : M_UP; nd = !up;
                        end else nm = M_IDLE;
                    end
                end
                M_DOOR: begin
                    if (c[m_floor]) leg = 1'b1;
                    else if (m_left == 1) begin
                        if (ahead(m_pend, m_floor, m_dir)) nm = m_dir ? M_UP : M_DOWN;
                        else if (ahead(m_pend, m_floor, !m_dir)) begin
                            nm = m_dir ? M_DOWN : M_UP; nd = !m_dir;
                        end else nm = M_IDLE;
                    end
                end
                default: ;
            endcase
            if (nm != m_mode) leg = 1'b1;
            if (nm == M_DOOR && m_mode != M_DOOR) np[nf] = 1'b0;
            if (nm == M_IDLE) m_left = 0;
            else m_left = leg ? ((nm == M_DOOR) ? DT : TT) : m_left - 1;
            m_mode  = nm;
            m_floor = nf;
            m_dir   = nd;
        end
        m_pend = np;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_floor = 0; m_dir = 1'b1; m_left = 0; m_pend = '0;
        end else begin
            model_step(bus_if.call_req, bus_if.estop);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("floor",   int'(bus_if.current_floor), m_floor);
            check("pending", int'(bus_if.pending),       int'(m_pend));
            check("idle",    int'(bus_if.idle),        (m_mode == M_IDLE) ? 1 : 0);
            check("up",      int'(bus_if.moving_up),   (m_mode == M_UP)   ? 1 : 0);
            check("down",    int'(bus_if.moving_down), (m_mode == M_DOWN) ? 1 : 0);
            check("door",    int'(bus_if.door_open),   (m_mode == M_DOOR) ? 1 : 0);
            check("onehot", int'(bus_if.idle) + int'(bus_if.moving_up) +
                            int'(bus_if.moving_down) + int'(bus_if.door_open), 1);
            if (bus_if.moving_up)   check("up_bound",   int'(bus_if.current_floor < FW'(NF - 1)), 1);
            if (bus_if.moving_down) check("down_bound", int'(bus_if.current_floor > FW'(0)), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [NF-1:0] m);
        bus_if.call_req = m;
        @(negedge clk);
        bus_if.call_req = '0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!bus_if.idle && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", int'(bus_if.idle), 1);
    endtask

    task automatic go(input logic [NF-1:0] m, input int budget);
        pulse(m);
        tick(1);
        wait_idle(budget);
    endtask

    task automatic wait_floor(input int f, input int budget);
        int k;
        k = 0;
        while (int'(bus_if.current_floor) != f && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_floor", int'(bus_if.current_floor), f);
    endtask

    task automatic lit_status(input string name, input int fl, input int i, input int u,
                              input int d, input int o);
        check({name, "_floor"}, int'(bus_if.current_floor), fl);
        check({name, "_idle"},  int'(bus_if.idle),        i);
        check({name, "_up"},    int'(bus_if.moving_up),   u);
        check({name, "_down"},  int'(bus_if.moving_down), d);
        check({name, "_door"},  int'(bus_if.door_open),   o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.call_req = '0;
        bus_if.estop    = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // 1: call at floor 0
        lit_status("rst", 0, 1, 0, 0, 0);
        check("rst_pend", int'(bus_if.pending), 0);
        pulse(NF'(1));
        check("s1_pend", int'(bus_if.pending), 1);
        check("s1_idle", int'(bus_if.idle), 1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            lit_status("s1_dwell", 0, 0, 0, 0, 1);
            check("s1_dwell_pend", int'(bus_if.pending), 0);
        end
        tick(1);
        lit_status("s1_end", 0, 1, 0, 0, 0);

        // 2: floor 0 -> 3
        pulse(NF'(1) << 3);
        tick(1);  lit_status("s2_go", 0, 0, 1, 0, 0);
        tick(3);  lit_status("s2_f0", 0, 0, 1, 0, 0);
        tick(1);  lit_status("s2_f1", 1, 0, 1, 0, 0);
        tick(4);  lit_status("s2_f2", 2, 0, 1, 0, 0);
        tick(4);  lit_status("s2_f3", 3, 0, 0, 0, 1);
        tick(2);  lit_status("s2_dw", 3, 0, 0, 0, 1);
        tick(1);  lit_status("s2_end", 3, 1, 0, 0, 0);
        check("s2_pend", int'(bus_if.pending), 0);

        // 3: calls 5 and 1 from floor 3 heading up
        pulse((NF'(1) << 5) | (NF'(1) << 1));
        check("s3_pend", int'(bus_if.pending), 34);
        tick(1);  lit_status("s3_go", 3, 0, 1, 0, 0);
        tick(8);  lit_status("s3_f5", 5, 0, 0, 0, 1);
        check("s3_pend5", int'(bus_if.pending), 2);
        tick(3);  lit_status("s3_rev", 5, 0, 0, 1, 0);
        tick(16); lit_status("s3_f1", 1, 0, 0, 0, 1);
        tick(3);  lit_status("s3_end", 1, 1, 0, 0, 0);
        check("s3_pend_end", int'(bus_if.pending), 0);
        pulse(NF'(1) | (NF'(1) << 2));
        tick(1);  lit_status("s3_dirdown", 1, 0, 0, 1, 0);
        wait_idle(60);
        go(NF'(1), 60);

        // 4: travel 0 -> 6 with an intermediate stop at 2
        pulse(NF'(1) << 6);
        tick(1);  lit_status("s4_go", 0, 0, 1, 0, 0);
        tick(4);  lit_status("s4_f1", 1, 0, 1, 0, 0);
        pulse(NF'(1) << 2);
        tick(3);  lit_status("s4_f2", 2, 0, 0, 0, 1);
        check("s4_pend", int'(bus_if.pending), 64);
        tick(3);  lit_status("s4_cont", 2, 0, 1, 0, 0);
        tick(16); lit_status("s4_f6", 6, 0, 0, 0, 1);
        tick(3);  lit_status("s4_end", 6, 1, 0, 0, 0);

        // 5: estop for 10 cycles during 0 -> 4
        go(NF'(1), 80);
        pulse(NF'(1) << 4);
        tick(4);
        bus_if.estop    = 1'b1;
        bus_if.call_req = NF'(1) << 7;
        tick(1);
        bus_if.call_req = '0;
        tick(4);  lit_status("s5_frz", 0, 0, 1, 0, 0);
        check("s5_pend", int'(bus_if.pending), 144);
        tick(5);  lit_status("s5_frz_end", 0, 0, 1, 0, 0);
        bus_if.estop = 1'b0;
        tick(12); lit_status("s5_f3", 3, 0, 1, 0, 0);
        tick(1);  lit_status("s5_f4", 4, 0, 0, 0, 1);
        tick(1);
        wait_idle(80);
        check("s5_final", int'(bus_if.current_floor), 7);

        // 6: async reset while moving up at floor 5 with floor 8 pending
        go(NF'(1) << 3, 80);
        pulse(NF'(1) << 8);
        wait_floor(5, 40);
        check("s6_moving", int'(bus_if.moving_up), 1);
        check("s6_pend8", int'(bus_if.pending), 256);
        #2 rst_n = 1'b0;
        #1 lit_status("s6_rst", 0, 1, 0, 0, 0);
        check("s6_rst_pend", int'(bus_if.pending), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        lit_status("s6_after", 0, 1, 0, 0, 0);
        check("s6_after_pend", int'(bus_if.pending), 0);

        // 7: dwell restart by a call for the open floor
        pulse(NF'(1) << 2);
        tick(9);  lit_status("s7_door", 2, 0, 0, 0, 1);
        tick(2);
        pulse(NF'(1) << 2);
        lit_status("s7_rs0", 2, 0, 0, 0, 1);
        check("s7_pend0", int'(bus_if.pending), 0);
        tick(1);  lit_status("s7_rs1", 2, 0, 0, 0, 1);
        check("s7_pend1", int'(bus_if.pending), 0);
        tick(1);  lit_status("s7_rs2", 2, 0, 0, 0, 1);
        tick(1);  lit_status("s7_end", 2, 1, 0, 0, 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
